ram_readback_checker: RTL and testbench

Read-back and verify stage that sits directly downstream of the single-port RAM pattern writer. After the writer has filled the 256×8 `ram` instance with an incrementing pattern, this block sweeps every address, compares each returned word against the expected value, and reports pass/fail, error count and first failing address. Its summary is also driven onto the board LEDs.

---
 rtl/ram_readback_checker.sv | 147 ++++++++++++++
 tb/tb_ram_readback_checker.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_readback_checker.sv
// Sweeps the RAM, compares every word against seed+address and reports pass/fail, error count and first failing address.
// Optional build macro RB_CHECKER_STOP_ON_ERR_EN: end the sweep at the first mismatch instead of counting all of them.
module ram_readback_checker #(
    parameter int unsigned ADDR_W     = 8,
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned RD_LATENCY = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] seed,
    output logic [ADDR_W-1:0] ram_address,
    output logic              ram_wren,
    input  logic [DATA_W-1:0] ram_q,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ADDR_W:0]   err_count,
    output logic [ADDR_W-1:0] first_err_addr,
    output logic [7:0]        LED
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   cnt_q, cnt_d;
    logic [DATA_W-1:0]   seed_q, seed_d;
    logic [ADDR_W:0]     err_q, err_d;
    logic [ADDR_W-1:0]   ferr_q, ferr_d;
    logic                done_q, done_d;
    logic                pass_q, pass_d;

    // Read pipeline: one valid bit and address tag per outstanding read.
    logic [RD_LATENCY-1:0] vld_q, vld_d;
    logic [ADDR_W-1:0]     tag_q [RD_LATENCY];
    logic [ADDR_W-1:0]     tag_d [RD_LATENCY];

    logic                tap_vld;
    logic [ADDR_W-1:0]   tap_tag;
    logic [DATA_W-1:0]   exp_data;
    logic                mismatch;

    assign tap_vld  = vld_q[RD_LATENCY-1];
    assign tap_tag  = tag_q[RD_LATENCY-1];
    assign exp_data = seed_q + DATA_W'(tap_tag);
    assign mismatch = tap_vld && (ram_q != exp_data);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        seed_d  = seed_q;
        err_d   = err_q;
        ferr_d  = ferr_q;
        done_d  = done_q;
        pass_d  = pass_q;

        vld_d[0] = (state_q == S_ISSUE);
        tag_d[0] = cnt_q;
        for (int unsigned i = 1; i < RD_LATENCY; i++) begin
            vld_d[i] = vld_q[i-1];
            tag_d[i] = tag_q[i-1];
        end

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    seed_d  = seed;
                    err_d   = '0;
                    ferr_d  = '0;
                    done_d  = 1'b0;
                    pass_d  = 1'b0;
                    cnt_d   = '0;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == '1) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (vld_q == '0) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                    pass_d  = (err_q == '0);
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Comparison comes last so a stop-on-error abort overrides the issue path.
        if (mismatch) begin
            err_d = err_q + 1'b1;
            if (err_q == '0) begin
                ferr_d = tap_tag;
            end
`ifdef RB_CHECKER_STOP_ON_ERR_EN
            state_d = S_DRAIN;
            vld_d   = '0;
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            seed_q  <= '0;
            err_q   <= '0;
            ferr_q  <= '0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            vld_q   <= '0;
            for (int unsigned i = 0; i < RD_LATENCY; i++) begin
                tag_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            seed_q  <= seed_d;
            err_q   <= err_d;
            ferr_q  <= ferr_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            vld_q   <= vld_d;
            for (int unsigned i = 0; i < RD_LATENCY; i++) begin
                tag_q[i] <= tag_d[i];
            end
        end
    end

    assign ram_address    = (state_q == S_ISSUE) ? cnt_q : '0;
    assign ram_wren       = 1'b0;
    assign busy           = (state_q == S_ISSUE) || (state_q == S_DRAIN);
    assign done           = done_q;
    assign pass           = pass_q;
    assign err_count      = err_q;
    assign first_err_addr = ferr_q;
    assign LED            = {err_q[4:0], busy, done_q, pass_q};

endmodule

// File: tb/tb_ram_readback_checker.sv
// Self-checking bench for ram_readback_checker: table of sweep scenarios plus hand-written multi-cycle sequences.
module tb_ram_readback_checker;

    localparam int RDL = 2;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] seed;
    logic [7:0] ram_address;
    logic       ram_wren;
    logic [7:0] ram_q;
    logic       busy;
    logic       done;
    logic       pass;
    logic [8:0] err_count;
    logic [7:0] first_err_addr;
    logic [7:0] LED;

    ram_readback_checker #(
        .ADDR_W(8),
        .DATA_W(8),
        .RD_LATENCY(RDL)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .seed(seed),
        .ram_address(ram_address),
        .ram_wren(ram_wren),
        .ram_q(ram_q),
        .busy(busy),
        .done(done),
        .pass(pass),
        .err_count(err_count),
        .first_err_addr(first_err_addr),
        .LED(LED)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM model: address sampled on each edge, data appears RDL edges after the address is presented.
    logic [7:0] mem [256];
    logic [7:0] apipe [RDL];
    always @(posedge clk) begin
        apipe[0] <= ram_address;
        for (int i = 1; i < RDL; i++) apipe[i] <= apipe[i-1];
    end
    assign ram_q = mem[apipe[RDL-1]];

    typedef struct {
        logic [7:0] seed;
        bit         c0_en;
        logic [7:0] c0;
        bit         c1_en;
        logic [7:0] c1;
        logic [8:0] err;
        logic [7:0] first;
        bit         pass;
        logic [7:0] led;
    } vec_t;

    typedef struct {
        int         done_edge;
        int         stop_edge;
        logic [8:0] err;
        logic [7:0] first;
        bit         pass;
        logic [7:0] led;
    } exp_t;

    vec_t vecs [6];
    exp_t exp_q [$];
    int   tests = 0;
    int   fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic load_ram(input vec_t v);
        for (int a = 0; a < 256; a++) mem[a] = 8'h03 + 8'(a);
        if (v.c0_en) mem[v.c0] = mem[v.c0] ^ 8'h5A;
        if (v.c1_en) mem[v.c1] = mem[v.c1] ^ 8'h5A;
    endtask

    function automatic exp_t make_exp(input vec_t v);
        exp_t x;
        x.done_edge = 256 + RDL + 1;
        x.stop_edge = 256;
        x.err       = v.err;
        x.first     = v.first;
        x.pass      = v.pass;
        x.led       = v.led;
`ifdef RB_CHECKER_STOP_ON_ERR_EN
        if (v.err != 0) begin
            x.err       = 9'd1;
            x.stop_edge = int'(v.first) + RDL + 1;
            x.done_edge = int'(v.first) + RDL + 2;
            x.led       = 8'h0A;
        end
`endif
        return x;
    endfunction

    task automatic chk_all_zero(input string tag);
        chk({tag, "_addr"}, 32'(ram_address), 0);
        chk({tag, "_wren"}, 32'(ram_wren), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_done"}, 32'(done), 0);
        chk({tag, "_pass"}, 32'(pass), 0);
        chk({tag, "_err"}, 32'(err_count), 0);
        chk({tag, "_first"}, 32'(first_err_addr), 0);
        chk({tag, "_led"}, 32'(LED), 0);
    endtask

    // Runs one sweep; edges are numbered from the edge that samples start (edge 0).
    task automatic sweep(input int idx, input bit mid_start, input bit start_at_done,
                         input bit rst_mid, output int done_e);
        exp_t x;
        exp_t r;
        int   e;
        bit   got;
        x = make_exp(vecs[idx]);
        seed  = vecs[idx].seed;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        seed  = 8'($urandom);
        exp_q.push_back(x);
        e      = 0;
        got    = 0;
        done_e = -1;
        while (!got && e < 2000) begin
            if (done) begin
                r = exp_q.pop_front();
                chk("done_edge", 32'(e), 32'(r.done_edge));
                chk("err_count", 32'(err_count), 32'(r.err));
                chk("first_err_addr", 32'(first_err_addr), 32'(r.first));
                chk("pass", 32'(pass), 32'(r.pass));
                chk("LED", 32'(LED), 32'(r.led));
                chk("busy_at_done", 32'(busy), 0);
                chk("wren", 32'(ram_wren), 0);
                done_e = e;
                got    = 1;
            end else begin
                if (!busy || ram_address != ((e < exp_q[0].stop_edge) ? 8'(e) : 8'h00)) begin
                    chk("busy_in_sweep", 32'(busy), 1);
                    chk("ram_address", 32'(ram_address), (e < exp_q[0].stop_edge) ? 32'(e) : 0);
                end
                if (rst_mid && e == 50) begin
                    rst = 1'b1;
                    #1;
                    chk_all_zero("rst_mid");
                    rst = 1'b0;
                    void'(exp_q.pop_front());
                    got = 1;
                end else begin
                    if (mid_start && e == 99) begin
                        start = 1'b1;
                        seed  = 8'h77;
                    end
                    if (start_at_done && e == x.done_edge - 1) begin
                        start = 1'b1;
                        seed  = 8'h44;
                    end
                    @(posedge clk);
                    #1;
                    start = 1'b0;
                    e++;
                end
            end
        end
        if (!got) begin
            chk("done_timeout", 32'(e), 32'(x.done_edge));
            exp_q.delete();
        end
        if (start_at_done && got) begin
            repeat (2) @(posedge clk);
            #1;
            chk("start_at_done_held", 32'(done), 1);
            chk("start_at_done_busy", 32'(busy), 0);
            chk("start_at_done_err", 32'(err_count), 32'(x.err));
        end
    endtask

    initial begin
        int de;
        vecs[0] = '{8'h03, 0, 8'h00, 0, 8'h00, 9'd0,   8'h00, 1, 8'h03};
        vecs[1] = '{8'h03, 1, 8'h10, 1, 8'hFF, 9'd2,   8'h10, 0, 8'h12};
        vecs[2] = '{8'h04, 0, 8'h00, 0, 8'h00, 9'd256, 8'h00, 0, 8'h02};
        vecs[3] = '{8'h03, 1, 8'h00, 0, 8'h00, 9'd1,   8'h00, 0, 8'h0A};
        vecs[4] = '{8'h03, 1, 8'hFF, 0, 8'h00, 9'd1,   8'hFF, 0, 8'h0A};
        vecs[5] = '{8'hFF, 1, 8'h80, 1, 8'h01, 9'd256, 8'h00, 0, 8'h02};

        rst   = 1'b1;
        start = 1'b0;
        seed  = 8'h00;
        load_ram(vecs[0]);
        repeat (3) @(posedge clk);
        #1;
        chk_all_zero("reset");
        rst = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 6; i++) begin
            load_ram(vecs[i]);
            sweep(i, 0, 0, 0, de);
            repeat (3) @(posedge clk);
            #1;
        end

        // Start while busy is ignored; a later start reruns from scratch.
        load_ram(vecs[0]);
        sweep(0, 1, 0, 0, de);
        if (de > 0) begin
            repeat (299 - de) @(posedge clk);
            #1;
            chk("done_held_idle", 32'(done), 1);
        end
        sweep(0, 0, 0, 0, de);
        chk("rerun_done_edge_abs", 32'(300 + de), 32'(300 + 256 + RDL + 1));

        // Start coinciding with the done edge is ignored.
        load_ram(vecs[1]);
        sweep(1, 0, 1, 0, de);

        // Mid-sweep reset, then a fresh sweep.
        load_ram(vecs[0]);
        sweep(0, 0, 0, 1, de);
        @(posedge clk);
        #1;
        chk("post_rst_busy", 32'(busy), 0);
        sweep(0, 0, 0, 0, de);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
